// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - 1024x768@60 (65 MHz) timing constants and window helper
package vga_pkg;

    localparam int CNT_W = 11;

    localparam int VGA_H_TOTAL      = 1344;
    localparam int VGA_H_ACTIVE     = 1024;
    localparam int VGA_H_SYNC_START = 1048;
    localparam int VGA_H_SYNC_LEN   = 136;

    localparam int VGA_V_TOTAL      = 806;
    localparam int VGA_V_ACTIVE     = 768;
    localparam int VGA_V_SYNC_START = 771;
    localparam int VGA_V_SYNC_LEN   = 6;

    localparam logic [11:0] RGB_BLACK = 12'h000;

    // Widened to 12 bits so lo+len can never wrap back into the window.
    function automatic logic in_window(input logic [CNT_W-1:0] c,
                                       input logic [CNT_W-1:0] lo,
                                       input logic [CNT_W-1:0] len);
        return ({1'b0, c} >= {1'b0, lo}) && ({1'b0, c} < ({1'b0, lo} + {1'b0, len}));
    endfunction

endpackage

// File: rtl/vga_if.sv
// rtl/vga_if.sv - pipeline video interface carrying counts, sync/blank and colour
interface vga_if;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;

    modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - one timing axis: wrapping counter with sync and blank windows
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int TOTAL      = VGA_H_TOTAL,
    parameter int ACTIVE     = VGA_H_ACTIVE,
    parameter int SYNC_START = VGA_H_SYNC_START,
    parameter int SYNC_LEN   = VGA_H_SYNC_LEN
) (
    input  logic             clk65MHz,
    input  logic             rst_n,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             wrap,
    output logic             sync,
    output logic             blank
);

    localparam logic [CNT_W-1:0] LAST    = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] ACT     = CNT_W'(ACTIVE);
    localparam logic [CNT_W-1:0] SYN_LO  = CNT_W'(SYNC_START);
    localparam logic [CNT_W-1:0] SYN_LEN = CNT_W'(SYNC_LEN);

    logic [CNT_W-1:0] count_nxt;

    // wrap is combinational so the next axis can advance on the same edge.
    assign wrap = en && (count == LAST);

    always_comb begin
        count_nxt = count;
        if (en) begin
            count_nxt = wrap ? '0 : count + 1'b1;
        end
    end

    // Flags come from count_nxt so they land in the same cycle as the count.
    always_ff @(posedge clk65MHz or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            sync  <= 1'b0;
            blank <= 1'b0;
        end else begin
            count <= count_nxt;
            sync  <= in_window(count_nxt, SYN_LO, SYN_LEN);
            blank <= (count_nxt >= ACT);
        end
    end

endmodule

// File: rtl/vga_frame_gen.sv
// rtl/vga_frame_gen.sv - VGA frame timing source with line/frame strobes and frame counter
module vga_frame_gen
    import vga_pkg::*;
#(
    parameter int H_TOTAL      = VGA_H_TOTAL,
    parameter int H_ACTIVE     = VGA_H_ACTIVE,
    parameter int H_SYNC_START = VGA_H_SYNC_START,
    parameter int H_SYNC_LEN   = VGA_H_SYNC_LEN,
    parameter int V_TOTAL      = VGA_V_TOTAL,
    parameter int V_ACTIVE     = VGA_V_ACTIVE,
    parameter int V_SYNC_START = VGA_V_SYNC_START,
    parameter int V_SYNC_LEN   = VGA_V_SYNC_LEN
) (
    input  logic       clk65MHz,
    input  logic       rst_n,
    input  logic       en,
    vga_if.out         vga_out,
    output logic       frame_start,
    output logic       line_end,
    output logic [7:0] frame_cnt
);

    localparam logic [CNT_W-1:0] H_PENULT = CNT_W'(H_TOTAL - 2);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);

    logic [CNT_W-1:0] hcount;
    logic [CNT_W-1:0] vcount;
    logic             h_wrap;
    logic             v_wrap;
    logic             frame_wrap;
    logic             hsync;
    logic             vsync;
    logic             hblnk;
    logic             vblnk;

    vga_axis_counter #(
        .TOTAL      (H_TOTAL),
        .ACTIVE     (H_ACTIVE),
        .SYNC_START (H_SYNC_START),
        .SYNC_LEN   (H_SYNC_LEN)
    ) u_h_axis (
        .clk65MHz (clk65MHz),
        .rst_n    (rst_n),
        .en       (en),
        .count    (hcount),
        .wrap     (h_wrap),
        .sync     (hsync),
        .blank    (hblnk)
    );

    vga_axis_counter #(
        .TOTAL      (V_TOTAL),
        .ACTIVE     (V_ACTIVE),
        .SYNC_START (V_SYNC_START),
        .SYNC_LEN   (V_SYNC_LEN)
    ) u_v_axis (
        .clk65MHz (clk65MHz),
        .rst_n    (rst_n),
        .en       (h_wrap),
        .count    (vcount),
        .wrap     (v_wrap),
        .sync     (vsync),
        .blank    (vblnk)
    );

    assign frame_wrap = v_wrap && (vcount == V_LAST);

    assign vga_out.hcount = hcount;
    assign vga_out.vcount = vcount;
    assign vga_out.hsync  = hsync;
    assign vga_out.vsync  = vsync;
    assign vga_out.hblnk  = hblnk;
    assign vga_out.vblnk  = vblnk;
    assign vga_out.rgb    = RGB_BLACK;

    // Strobes look one count ahead; reset's (0,0) is never a wrap, so no strobe.
    always_ff @(posedge clk65MHz or negedge rst_n) begin
        if (!rst_n) begin
            frame_start <= 1'b0;
            line_end    <= 1'b0;
            frame_cnt   <= 8'd0;
        end else begin
            frame_start <= frame_wrap;
            line_end    <= en && (hcount == H_PENULT);
            if (frame_wrap) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_vga_frame_gen.sv
// tb/tb_vga_frame_gen.sv - self-checking bench for vga_frame_gen against a pixel-index model
module tb_vga_frame_gen;

    localparam int FHT = 1344, FHA = 1024, FHSS = 1048, FHSL = 136;
    localparam int FVT = 806,  FVA = 768,  FVSS = 771,  FVSL = 6;
    localparam int SHT = 16, SHA = 12, SHSS = 13, SHSL = 2;
    localparam int SVT = 10, SVA = 8,  SVSS = 8,  SVSL = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en_f = 1'b0;
    logic en_s = 1'b0;

    always #5 clk = ~clk;

    vga_if vif_f ();
    vga_if vif_s ();

    logic       fs_fo, le_fo, fs_so, le_so;
    logic [7:0] fc_fo, fc_so;

    vga_frame_gen dut_f (
        .clk65MHz    (clk),
        .rst_n       (rst_n),
        .en          (en_f),
        .vga_out     (vif_f),
        .frame_start (fs_fo),
        .line_end    (le_fo),
        .frame_cnt   (fc_fo)
    );

    vga_frame_gen #(
        .H_TOTAL (SHT), .H_ACTIVE (SHA), .H_SYNC_START (SHSS), .H_SYNC_LEN (SHSL),
        .V_TOTAL (SVT), .V_ACTIVE (SVA), .V_SYNC_START (SVSS), .V_SYNC_LEN (SVSL)
    ) dut_s (
        .clk65MHz    (clk),
        .rst_n       (rst_n),
        .en          (en_s),
        .vga_out     (vif_s),
        .frame_start (fs_so),
        .line_end    (le_so),
        .frame_cnt   (fc_so)
    );

    int checks = 0;
    int errors = 0;

    // Model state: pixel index within the frame, frames completed, strobes.
    int p_f = 0, fr_f = 0, p_s = 0, fr_s = 0;
    bit mfs_f = 0, mle_f = 0, mfs_s = 0, mle_s = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_f = 0; fr_f = 0; mfs_f = 0; mle_f = 0;
            p_s = 0; fr_s = 0; mfs_s = 0; mle_s = 0;
        end else begin
            if (en_f) begin
                p_f   = (p_f + 1) % (FHT * FVT);
                mfs_f = (p_f == 0);
                if (mfs_f) fr_f = (fr_f + 1) % 256;
                mle_f = ((p_f % FHT) == FHT - 1);
            end else begin
                mfs_f = 0; mle_f = 0;
            end
            if (en_s) begin
                p_s   = (p_s + 1) % (SHT * SVT);
                mfs_s = (p_s == 0);
                if (mfs_s) fr_s = (fr_s + 1) % 256;
                mle_s = ((p_s % SHT) == SHT - 1);
            end else begin
                mfs_s = 0; mle_s = 0;
            end
        end
    end

    function automatic logic [47:0] expv(int p, int fr, bit fs, bit le, int ht, int ha,
                                         int hss, int hsl, int va, int vss, int vsl);
        int h, v;
        h = p % ht;
        v = p / ht;
        return {11'(h), 11'(v), (h >= hss && h < hss + hsl), (v >= vss && v < vss + vsl),
                (h >= ha), (v >= va), 12'h000, fs, le, 8'(fr)};
    endfunction

    function automatic logic [47:0] exp_f();
        return expv(p_f, fr_f, mfs_f, mle_f, FHT, FHA, FHSS, FHSL, FVA, FVSS, FVSL);
    endfunction

    function automatic logic [47:0] exp_s();
        return expv(p_s, fr_s, mfs_s, mle_s, SHT, SHA, SHSS, SHSL, SVA, SVSS, SVSL);
    endfunction

    function automatic logic [47:0] obs_f();
        return {vif_f.hcount, vif_f.vcount, vif_f.hsync, vif_f.vsync, vif_f.hblnk,
                vif_f.vblnk, vif_f.rgb, fs_fo, le_fo, fc_fo};
    endfunction

    function automatic logic [47:0] obs_s();
        return {vif_s.hcount, vif_s.vcount, vif_s.hsync, vif_s.vsync, vif_s.hblnk,
                vif_s.vblnk, vif_s.rgb, fs_so, le_so, fc_so};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        en_f  = 1'b1;
        en_s  = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (obs_f() !== 48'h0) begin
            errors++;
            $display("FAIL reset_full got %h want 0", obs_f());
        end
        checks++;
        if (obs_s() !== 48'h0) begin
            errors++;
            $display("FAIL reset_small got %h want 0", obs_s());
        end
    endtask

    task automatic test_first_line();
        int le_n = 0;
        int le_h = -1;
        rst_n = 1'b1;
        for (int i = 0; i < FHT; i++) begin
            @(negedge clk);
            checks++;
            if (obs_f() !== exp_f()) begin
                errors++;
                $display("FAIL first_line_cycle%0d got %h want %h", i, obs_f(), exp_f());
            end
            if (le_fo === 1'b1) begin
                le_n++;
                le_h = int'(vif_f.hcount);
            end
        end
        checks++;
        if (vif_f.hcount !== 11'd0 || vif_f.vcount !== 11'd1) begin
            errors++;
            $display("FAIL first_line_pos got (%0d,%0d) want (0,1)", vif_f.hcount, vif_f.vcount);
        end
        checks++;
        if (le_n != 1 || le_h != FHT - 1) begin
            errors++;
            $display("FAIL first_line_le got n=%0d h=%0d want n=1 h=%0d", le_n, le_h, FHT - 1);
        end
    endtask

    task automatic test_line_scan();
        int hs_first = -1, hs_last = -1, hs_n = 0;
        int hb_first = -1, hb_last = -1, hb_n = 0;
        for (int i = 0; i < FHT; i++) begin
            if (vif_f.hsync === 1'b1) begin
                if (hs_first < 0) hs_first = int'(vif_f.hcount);
                hs_last = int'(vif_f.hcount);
                hs_n++;
            end
            if (vif_f.hblnk === 1'b1) begin
                if (hb_first < 0) hb_first = int'(vif_f.hcount);
                hb_last = int'(vif_f.hcount);
                hb_n++;
            end
            @(negedge clk);
        end
        checks++;
        if (hs_first != FHSS || hs_last != FHSS + FHSL - 1 || hs_n != FHSL) begin
            errors++;
            $display("FAIL hsync_window got %0d..%0d n=%0d want %0d..%0d n=%0d",
                     hs_first, hs_last, hs_n, FHSS, FHSS + FHSL - 1, FHSL);
        end
        checks++;
        if (hb_first != FHA || hb_last != FHT - 1 || hb_n != FHT - FHA) begin
            errors++;
            $display("FAIL hblnk_window got %0d..%0d n=%0d want %0d..%0d n=%0d",
                     hb_first, hb_last, hb_n, FHA, FHT - 1, FHT - FHA);
        end
    endtask

    task automatic test_en_hold();
        logic [47:0] snap;
        int guard = 0;
        en_f = 1'b1;
        while (vif_f.hcount !== 11'(FHSS - 1) && guard < 2 * FHT) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (vif_f.hcount !== 11'(FHSS - 1)) begin
            errors++;
            $display("FAIL en_hold_reach got %0d want %0d", vif_f.hcount, FHSS - 1);
        end
        en_f = 1'b0;
        snap = obs_f();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            checks++;
            if (obs_f() !== snap || vif_f.hsync !== 1'b0) begin
                errors++;
                $display("FAIL en_hold_cycle%0d got %h want %h", i, obs_f(), snap);
            end
        end
        en_f = 1'b1;
        @(negedge clk);
        checks++;
        if (vif_f.hcount !== 11'(FHSS) || vif_f.hsync !== 1'b1) begin
            errors++;
            $display("FAIL en_resume got h=%0d hs=%b want h=%0d hs=1", vif_f.hcount, vif_f.hsync, FHSS);
        end
        checks++;
        if (obs_f() !== exp_f()) begin
            errors++;
            $display("FAIL en_resume_model got %h want %h", obs_f(), exp_f());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 2000; i++) begin
            en_f = ($urandom_range(3) != 0);
            en_s = ($urandom_range(3) != 0);
            @(negedge clk);
            checks++;
            if (obs_f() !== exp_f()) begin
                errors++;
                $display("FAIL random_full_cycle%0d got %h want %h", i, obs_f(), exp_f());
            end
            checks++;
            if (obs_s() !== exp_s()) begin
                errors++;
                $display("FAIL random_small_cycle%0d got %h want %h", i, obs_s(), exp_s());
            end
        end
    endtask

    task automatic test_frames();
        int nfs = 0, vs_n = 0;
        int vs_first = -1, vs_last = -1, vb_first = -1, vb_last = -1;
        rst_n = 1'b0;
        en_f  = 1'b1;
        en_s  = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (vif_s.hcount !== 11'd1 || vif_s.vcount !== 11'd0 || fs_so !== 1'b0) begin
            errors++;
            $display("FAIL release_first_edge got (%0d,%0d) fs=%b want (1,0) fs=0",
                     vif_s.hcount, vif_s.vcount, fs_so);
        end
        for (int i = 1; i < SHT * SVT; i++) begin
            @(negedge clk);
            if (fs_so === 1'b1) nfs++;
            if (vif_s.vsync === 1'b1) begin
                if (vs_first < 0) vs_first = int'(vif_s.vcount);
                vs_last = int'(vif_s.vcount);
                vs_n++;
            end
            if (vif_s.vblnk === 1'b1) begin
                if (vb_first < 0) vb_first = int'(vif_s.vcount);
                vb_last = int'(vif_s.vcount);
            end
        end
        checks++;
        if (nfs != 1 || fs_so !== 1'b1 || vif_s.hcount !== 11'd0 || vif_s.vcount !== 11'd0
            || fc_so !== 8'd1) begin
            errors++;
            $display("FAIL frame_one got nfs=%0d fs=%b (%0d,%0d) cnt=%0d want 1 1 (0,0) 1",
                     nfs, fs_so, vif_s.hcount, vif_s.vcount, fc_so);
        end
        checks++;
        if (vs_first != SVSS || vs_last != SVSS + SVSL - 1 || vs_n != SVSL * SHT) begin
            errors++;
            $display("FAIL vsync_window got %0d..%0d n=%0d want %0d..%0d n=%0d",
                     vs_first, vs_last, vs_n, SVSS, SVSS + SVSL - 1, SVSL * SHT);
        end
        checks++;
        if (vb_first != SVA || vb_last != SVT - 1) begin
            errors++;
            $display("FAIL vblnk_window got %0d..%0d want %0d..%0d", vb_first, vb_last, SVA, SVT - 1);
        end
        nfs = 0;
        for (int i = 0; i < 255 * SHT * SVT; i++) begin
            @(negedge clk);
            if (fs_so === 1'b1) nfs++;
        end
        checks++;
        if (nfs != 255 || fc_so !== 8'd0 || fs_so !== 1'b1) begin
            errors++;
            $display("FAIL frame_wrap256 got nfs=%0d cnt=%0d fs=%b want 255 0 1", nfs, fc_so, fs_so);
        end
    endtask

    task automatic test_midframe_reset();
        int guard = 0;
        int nfs = 0;
        en_s = 1'b1;
        while (!(vif_s.hcount === 11'd6 && vif_s.vcount === 11'd4) && guard < 2 * SHT * SVT) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (vif_s.hcount !== 11'd6 || vif_s.vcount !== 11'd4) begin
            errors++;
            $display("FAIL midreset_reach got (%0d,%0d) want (6,4)", vif_s.hcount, vif_s.vcount);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs_s() !== 48'h0 || obs_f() !== 48'h0) begin
            errors++;
            $display("FAIL midreset_async got %h / %h want 0", obs_s(), obs_f());
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i < SHT * SVT; i++) begin
            @(negedge clk);
            if (fs_so === 1'b1) nfs++;
        end
        checks++;
        if (nfs != 0) begin
            errors++;
            $display("FAIL midreset_early_fs got %0d want 0", nfs);
        end
        @(negedge clk);
        checks++;
        if (fs_so !== 1'b1 || fc_so !== 8'd1) begin
            errors++;
            $display("FAIL midreset_frame got fs=%b cnt=%0d want 1 1", fs_so, fc_so);
        end
    endtask

    initial begin
        test_reset();
        test_first_line();
        test_line_scan();
        test_en_hold();
        test_random();
        test_frames();
        test_midframe_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
